fadd_arbiter: RTL and testbench
===============================

# fadd_arbiter

Round-robin scheduler that shares one combinational single-precision adder (`fadd`) among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the granted pair and drives it into the adder. It then registers the adder result and returns it on a single shared response port, tagged with the requester index. The block sits between the FPU front-end issue logic and the shared `fadd` instance, with a two-stage pipeline and full backpressure.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester index; must equal `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  bit i set: requester i presents an operand pair.
- `req_a`  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*NUM_REQ  operand B; same packing as `req_a`.
- `req_ready`  out  NUM_REQ  one-hot grant; handshake completes when valid and ready are both high.
- `fa_num1`  out  32  operand A driven to the adder (from the S1 register).
- `fa_num2`  out  32  operand B driven to the adder (from the S1 register).
- `fa_sum`  in  32  combinational adder result for `fa_num1` + `fa_num2`.
- `rsp_valid`  out  1  response available.
- `rsp_data`  out  32  registered sum.
- `rsp_id`  out  ID_W  index of the requester that issued the operation.
- `rsp_ready`  in  1  consumer accepts the response.
- `idle`  out  1  high when S1 and S2 are both empty.

## Operation

- **Stage S1 (operand register).**
  - Holds `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - `fa_num1 = s1_a` and `fa_num2 = s1_b` at all times.
- **Stage S2 (response register).**
  - Holds `rsp_valid`, `rsp_data`, `rsp_id`.
  - Captures `fa_sum` and `s1_id` from S1.
- **Advance conditions.**
  - `s2_load = s1_valid && (!rsp_valid || rsp_ready)`.
  - `s1_free = !s1_valid || s2_load`.
- **Arbitration.**
  - Combinational round-robin over `req_valid`, enabled only when `s1_free`.
  - Priority search starts at `ptr+1` (mod NUM_REQ) and wraps.
  - The winner's `req_ready` bit is set; all other bits are 0.
  - With no valid requests, or with `s1_free` low, `req_ready` is all-zero.
  - `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- **On grant of requester g:**
  - S1 loads `req_a[g]`, `req_b[g]`, and `g`, and sets `s1_valid`.
  - `ptr <= g`.
- **S1 drain without refill:** if S1 advances (`s2_load`) and no grant occurs, `s1_valid` clears.
- **S2 behaviour:**
  - On `s2_load`, S2 loads and sets `rsp_valid`.
  - If `rsp_ready` is high with no `s2_load`, `rsp_valid` clears.
  - Otherwise S2 holds, and `rsp_data`/`rsp_id` stay stable while `rsp_valid && !rsp_ready`.
- **Requester protocol:** a requester keeps `req_valid` and its operands stable until granted. The block does not check this.
- **Width rules.** `NUM_REQ` and `ID_W` mismatch is an elaboration error. `ptr` is `ID_W` bits and wraps NUM_REQ-1 → 0. No arithmetic on the data path beyond the muxes.

## Timing

- **Reset** (sampled at a rising edge with `rst` high):
  - `s1_valid=0`, `rsp_valid=0`.
  - `s1_a`, `s1_b`, `rsp_data` = 0, so `fa_num1 = fa_num2 = 0`.
  - `s1_id=0`, `rsp_id=0`.
  - `ptr=NUM_REQ-1`, so requester 0 has first priority.
  - `idle=1`.
  - `req_ready=0` while `rst` is high.
- **Reset mid-operation:** in-flight operations in S1 and S2 are discarded with no response.
- **Latency:** a handshake in cycle T gives `rsp_valid` high in cycle T+2, with `rsp_data = fa_sum` as evaluated in cycle T+1.
- **Throughput:** one operation per cycle while `rsp_ready` is held high.
- **Backpressure:**
  - With `rsp_ready` low and S2 full, S1 holds and stays valid. At most 2 operations are in flight.
  - When `rsp_ready` rises, S2 accepts S1 and a new grant occurs in the same cycle.
- **Simultaneous events:**
  - Several requests in one cycle: exactly one grant.
  - Response consume and S1 advance in the same cycle: S2 reloads with no bubble.

## Test plan

In all scenarios the bench stubs the adder as `fa_sum = fa_num1 ^ fa_num2`.

1. **Reset values.** Hold `rst` 2 cycles with all `req_valid=1` → `req_ready=0`, `rsp_valid=0`, `idle=1`, `fa_num1=fa_num2=0` throughout.
2. **Single request.** Requester 2 sends a=0x3F800000, b=0x40000000 at cycle T → `req_ready=0100` at T; `rsp_valid=1`, `rsp_data=0x7F800000`, `rsp_id=2` at T+2; `idle=1` at T+3 with `rsp_ready=1`.
3. **Round-robin fairness.** All 4 requesters valid continuously, `rsp_ready=1` → grants 0,1,2,3,0,1… one per cycle; `rsp_id` follows the same sequence two cycles later.
4. **Backpressure.** `rsp_ready=0` with requesters 1 and 3 valid → two grants (1, then 3), then `req_ready=0`; `rsp_id=1` held stable. Raise `rsp_ready` for 1 cycle → `rsp_id=3` next cycle, and requester 1 is granted again in that same cycle.
5. **Reset mid-flight.** Grant requester 0 at T, assert `rst` at T+1 → `rsp_valid` never rises for that operation; the next grant after reset goes to requester 0 if valid.

Source files
------------

// File: rtl/fadd_arbiter_if.sv
// Bundle for the fadd_arbiter: requester ports, shared-adder ports and the response port.
// The arbiter uses the slave view; the issue side / environment uses the master view.
interface fadd_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           fa_num1;
  logic [31:0]           fa_num2;
  logic [31:0]           fa_sum;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, fa_sum, rsp_ready,
    output req_ready, fa_num1, fa_num2, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, fa_sum, rsp_ready,
    input  req_ready, fa_num1, fa_num2, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/fadd_arbiter.sv
// Round-robin share of one combinational fadd among NUM_REQ requesters.
// Two-stage pipeline: S1 holds the granted operands, S2 holds the tagged sum.
module fadd_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic          clk,
  input  logic          rst,
  fadd_arbiter_if.slave bus,
  output logic          idle
);

  if (ID_W != $clog2(NUM_REQ)) begin : g_id_w_check
    $error("fadd_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("fadd_arbiter: NUM_REQ must be in 2..8");
  end

  // Pipeline state
  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_a_q, s1_a_d;
  logic [31:0]     s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Advance and arbitration
  logic               s2_load;
  logic               s1_free;
  logic               hi_found, lo_found;
  logic [ID_W-1:0]    hi_id, lo_id;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [31:0]        gnt_a, gnt_b;

  assign s2_load = s1_valid_q && (!rsp_valid_q || bus.rsp_ready);
  assign s1_free = !s1_valid_q || s2_load;

  // Rotating priority: the first valid index above ptr wins, otherwise the first at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i]) begin
        if (ID_W'(i) > ptr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_id    = ID_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = ID_W'(i);
        end
      end
    end
    gnt_any = s1_free && !rst && (hi_found || lo_found);
    gnt_id  = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    gnt_oh = '0;
    gnt_a  = '0;
    gnt_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_oh[i] = gnt_any;
        gnt_a     = bus.req_a[i*32 +: 32];
        gnt_b     = bus.req_b[i*32 +: 32];
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;

    if (gnt_any) begin
      s1_valid_d = 1'b1;
      s1_a_d     = gnt_a;
      s1_b_d     = gnt_b;
      s1_id_d    = gnt_id;
      ptr_d      = gnt_id;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus.fa_sum;
      rsp_id_d    = s1_id_q;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.req_ready = gnt_oh;
  assign bus.fa_num1   = s1_a_q;
  assign bus.fa_num2   = s1_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign idle          = !s1_valid_q && !rsp_valid_q;

  // Structural invariants of the grant and response paths.
  a_grant_onehot: assert property (@(posedge clk) $onehot0(gnt_oh));
  a_no_grant_in_rst: assert property (@(posedge clk) rst |-> gnt_oh == '0);
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid_q && !bus.rsp_ready) |=> (rsp_valid_q && $stable(rsp_data_q) && $stable(rsp_id_q)));

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: directed scenarios plus a randomized run against a queue-based
// model of a capacity-2 in-order pipeline with round-robin issue.
module tb_fadd_arbiter;
  localparam int NREQ = 4;

  logic clk;
  logic rst;
  logic idle;

  fadd_arbiter_if #(.NUM_REQ(NREQ), .ID_W(2)) bus ();

  fadd_arbiter #(.NUM_REQ(NREQ), .ID_W(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .idle (idle)
  );

  // Adder stub
  assign bus.fa_sum = bus.fa_num1 ^ bus.fa_num2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    int          gc;
  } op_t;

  // Model: in-order ops in flight; an op is visible on the response port two cycles after grant.
  op_t q[$];
  int  mptr = NREQ - 1;
  int  cyc  = 0;

  function automatic bit m_rsp_valid();
    return q.size() > 0 && (cyc - q[0].gc) >= 2;
  endfunction

  function automatic bit m_s1_full();
    return q.size() == 2 || (q.size() == 1 && !m_rsp_valid());
  endfunction

  function automatic int m_grant();
    if (rst) return -1;
    if (q.size() >= 2 && !bus.rsp_ready) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (mptr + k) % NREQ;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    int  g;
    op_t o;
    @(posedge clk);
    g = m_grant();
    if (rst) begin
      q.delete();
      mptr = NREQ - 1;
    end else begin
      if (m_rsp_valid() && bus.rsp_ready) void'(q.pop_front());
      if (g >= 0) begin
        o.id = g;
        o.a  = bus.req_a[g*32 +: 32];
        o.b  = bus.req_b[g*32 +: 32];
        o.gc = cyc;
        q.push_back(o);
        mptr = g;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*32 +: 32] = $urandom;
      bus.req_b[i*32 +: 32] = $urandom;
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready !== 4'b0000) begin
        bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
      end
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
      end
      total++;
      if (idle !== 1'b1) begin
        bad++; $display("FAIL reset_idle got=%b exp=1", idle);
      end
      total++;
      if (bus.fa_num1 !== 32'h0 || bus.fa_num2 !== 32'h0) begin
        bad++; $display("FAIL reset_fa_num got=%h/%h exp=0/0", bus.fa_num1, bus.fa_num2);
      end
      tick();
    end
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_a[2*32 +: 32] = 32'h3F80_0000;
    bus.req_b[2*32 +: 32] = 32'h4000_0000;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.fa_num1 !== 32'h3F80_0000) begin
      bad++; $display("FAIL single_s1 got=%b/%h exp=0/3f800000", bus.rsp_valid, bus.fa_num1);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h7F80_0000 || bus.rsp_id !== 2'd2) begin
      bad++; $display("FAIL single_rsp got=%b/%h/%0d exp=1/7f800000/2",
                      bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
    @(negedge clk);
    total++;
    if (idle !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle got=%b/%b exp=1/0", idle, bus.rsp_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] er;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      er = 4'b0001 << (k % 4);
      total++;
      if (bus.req_ready !== er) begin
        bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, bus.req_ready, er);
      end
      if (k >= 2) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != (k - 2) % 4) begin
          bad++; $display("FAIL rr_rsp_id k=%0d got=%b/%0d exp=1/%0d",
                          k, bus.rsp_valid, bus.rsp_id, (k - 2) % 4);
        end
        total++;
        if (bus.rsp_data !== (q[0].a ^ q[0].b)) begin
          bad++; $display("FAIL rr_rsp_data k=%0d got=%h exp=%h", k, bus.rsp_data, q[0].a ^ q[0].b);
        end
      end
      tick();
      bus.req_a[(k % 4)*32 +: 32] = $urandom;
      bus.req_b[(k % 4)*32 +: 32] = $urandom;
    end
    bus.req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, b1;
    do_reset();
    a1 = $urandom;
    b1 = $urandom;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    bus.req_a[1*32 +: 32] = a1;
    bus.req_b[1*32 +: 32] = b1;
    bus.req_a[3*32 +: 32] = $urandom;
    bus.req_b[3*32 +: 32] = $urandom;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_grant1 got=%b exp=0010", bus.req_ready);
    end
    tick();
    bus.req_a[1*32 +: 32] = $urandom;
    bus.req_b[1*32 +: 32] = $urandom;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b1000) begin
      bad++; $display("FAIL bp_grant3 got=%b exp=1000", bus.req_ready);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_stall c=%0d got=%b exp=0000", c, bus.req_ready);
      end
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== (a1 ^ b1)) begin
        bad++; $display("FAIL bp_hold c=%0d got=%b/%0d/%h exp=1/1/%h",
                        c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, a1 ^ b1);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_regrant got=%b exp=0010", bus.req_ready);
    end
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3) begin
      bad++; $display("FAIL bp_next_id got=%b/%0d exp=1/3", bus.rsp_valid, bus.rsp_id);
    end
    total++;
    if (bus.req_ready !== 4'b0000) begin
      bad++; $display("FAIL bp_refull got=%b exp=0000", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_a[31:0] = $urandom;
    bus.req_b[31:0] = $urandom;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("FAIL mid_grant got=%b exp=0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++; $display("FAIL mid_no_rsp c=%0d got=%b exp=0", c, bus.rsp_valid);
      end
      tick();
    end
    bus.req_valid = 4'b1111;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("FAIL mid_first got=%b exp=0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic [3:0] er;
    int         eg;
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          bus.req_a[i*32 +: 32] = $urandom;
          bus.req_b[i*32 +: 32] = $urandom;
        end
      end
      bus.req_valid = pend;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      eg = m_grant();
      er = (eg >= 0) ? (4'b0001 << eg) : 4'b0000;
      total++;
      if (bus.req_ready !== er) begin
        bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.req_ready, er);
      end
      total++;
      if (bus.rsp_valid !== m_rsp_valid()) begin
        bad++; $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, m_rsp_valid());
      end
      if (m_rsp_valid()) begin
        total++;
        if (bus.rsp_data !== (q[0].a ^ q[0].b) || int'(bus.rsp_id) != q[0].id) begin
          bad++; $display("FAIL rand_rsp c=%0d got=%h/%0d exp=%h/%0d",
                          c, bus.rsp_data, bus.rsp_id, q[0].a ^ q[0].b, q[0].id);
        end
      end
      total++;
      if (idle !== (q.size() == 0)) begin
        bad++; $display("FAIL rand_idle c=%0d got=%b exp=%b", c, idle, q.size() == 0);
      end
      if (m_s1_full()) begin
        total++;
        if (bus.fa_num1 !== q[q.size()-1].a || bus.fa_num2 !== q[q.size()-1].b) begin
          bad++; $display("FAIL rand_fa_num c=%0d got=%h/%h exp=%h/%h", c, bus.fa_num1,
                          bus.fa_num2, q[q.size()-1].a, q[q.size()-1].b);
        end
      end
      tick();
      if (eg >= 0) pend[eg] = 1'b0;
    end
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
